// File: rtl/inv_mix_cols_seq.sv
// Sequenced KLEIN inverse MixColumns: a shared group of LANES row units walks the
// eight output bytes of a two-column state, LANES bytes per cycle.
module inv_mix_cols_seq #(
    parameter int unsigned LANES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] in_data,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] out_data,
    output logic        busy
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8)) begin : g_bad_lanes
        $error("inv_mix_cols_seq: LANES must be 1, 2, 4 or 8");
    end

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] mul_0e(input logic [7:0] a);
        logic [7:0] x2, x4, x8;
        x2 = xtime(a);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return x8 ^ x4 ^ x2;
    endfunction

    function automatic logic [7:0] mul_0b(input logic [7:0] a);
        logic [7:0] x2, x8;
        x2 = xtime(a);
        x8 = xtime(xtime(x2));
        return x8 ^ x2 ^ a;
    endfunction

    function automatic logic [7:0] mul_0d(input logic [7:0] a);
        logic [7:0] x4, x8;
        x4 = xtime(xtime(a));
        x8 = xtime(x4);
        return x8 ^ x4 ^ a;
    endfunction

    function automatic logic [7:0] mul_09(input logic [7:0] a);
        return xtime(xtime(xtime(a))) ^ a;
    endfunction

    state_e     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic       init_q;
    logic [7:0] st_q  [8];
    logic [7:0] st_d  [8];
    logic [7:0] res_q [8];
    logic [7:0] res_d [8];

    logic [2:0] lane_k   [LANES];
    logic [7:0] lane_val [LANES];
    logic       last_group;

    // Each lane rotates its column's operands into the fixed 0e/0b/0d/09 multipliers.
    for (genvar j = 0; j < LANES; j++) begin : g_lane
        logic       c;
        logic [1:0] r;
        assign lane_k[j]   = cnt_q + 3'(j);
        assign c           = lane_k[j][2];
        assign r           = lane_k[j][1:0];
        assign lane_val[j] = mul_0e(st_q[{c, r}])
                           ^ mul_0b(st_q[{c, r + 2'd1}])
                           ^ mul_0d(st_q[{c, r + 2'd2}])
                           ^ mul_09(st_q[{c, r + 2'd3}]);
    end

    assign last_group = ({1'b0, cnt_q} + 4'(LANES)) == 4'd8;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        st_d      = st_q;
        res_d     = res_q;
        in_ready  = init_q && (state_q == StIdle);
        out_valid = (state_q == StDone);
        busy      = (state_q != StIdle);
        if (flush) begin
            state_d = StIdle;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (in_valid && in_ready) begin
                        for (int b = 0; b < 8; b++) st_d[b] = in_data[63-8*b -: 8];
                        cnt_d   = '0;
                        state_d = StRun;
                    end
                end
                StRun: begin
                    for (int unsigned j = 0; j < LANES; j++) res_d[lane_k[j]] = lane_val[j];
                    cnt_d = cnt_q + 3'(LANES);
                    if (last_group) state_d = StDone;
                end
                StDone: begin
                    if (out_ready) state_d = StIdle;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_comb begin
        out_data = '0;
        for (int b = 0; b < 8; b++) out_data[63-8*b -: 8] = res_q[b];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            init_q  <= 1'b0;
            for (int b = 0; b < 8; b++) begin
                st_q[b]  <= '0;
                res_q[b] <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            init_q  <= 1'b1;
            st_q    <= st_d;
            res_q   <= res_d;
        end
    end

endmodule

// File: tb/tb_inv_mix_cols_seq.sv
// Bench for inv_mix_cols_seq: four instances (LANES 1/2/4/8) share stimulus; instance 0
// carries the handshake, flush and reset scenarios against a GF(2^8) matrix model.
module tb_inv_mix_cols_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [63:0] in_data;
    logic        flush;
    logic        out_ready;
    logic        ir [4];
    logic        ov [4];
    logic        bz [4];
    logic [63:0] od [4];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        inv_mix_cols_seq #(.LANES(1 << g)) u_dut (
            .clk      (clk),
            .rst_n    (rst_n),
            .in_valid (in_valid),
            .in_ready (ir[g]),
            .in_data  (in_data),
            .flush    (flush),
            .out_valid(ov[g]),
            .out_ready(out_ready),
            .out_data (od[g]),
            .busy     (bz[g])
        );
    end

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
        end
        return p;
    endfunction

    // Inverse MixColumns as a plain matrix product over each column.
    function automatic logic [63:0] model(input logic [63:0] d);
        logic [7:0]  s  [8];
        logic [7:0]  cf [4];
        logic [7:0]  acc;
        logic [63:0] o;
        cf = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
        o  = '0;
        for (int b = 0; b < 8; b++) s[b] = d[63-8*b -: 8];
        for (int c = 0; c < 2; c++) begin
            for (int r = 0; r < 4; r++) begin
                acc = 8'h00;
                for (int m = 0; m < 4; m++) acc = acc ^ gmul(cf[(m - r + 4) % 4], s[c*4+m]);
                o[63-8*(c*4+r) -: 8] = acc;
            end
        end
        return o;
    endfunction

    task automatic chk1(input string tag, input logic got, input logic exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%b exp=%b", tag, got, exp);
        end
    endtask

    task automatic chk64(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // All instances idle: accept vec together, check each one's latency and result.
    task automatic run_lanes(input logic [63:0] vec);
        logic [63:0] exp;
        int          lat;
        exp       = model(vec);
        in_data   = vec;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        for (int n = 1; n <= 8; n++) begin
            step();
            for (int g = 0; g < 4; g++) begin
                lat = 8 >> g;
                chk1($sformatf("lanes%0d_valid_n%0d", 1 << g, n), ov[g], n == lat);
                if (n == lat) chk64($sformatf("lanes%0d_data", 1 << g), od[g], exp);
            end
            chk1("run_in_ready", ir[0], 1'b0);
        end
        step();
        chk1("idle_after_out", ir[0], 1'b1);
    endtask

    // Instance 0 only: send vec and check the result within a bounded wait.
    task automatic send_check(input string tag, input logic [63:0] vec);
        int waited;
        in_data   = vec;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        waited   = 0;
        while (!ov[0] && waited < 20) begin
            step();
            waited++;
        end
        chk1({tag, "_valid"}, ov[0], 1'b1);
        chk64({tag, "_data"}, od[0], model(vec));
        step();
    endtask

    logic [63:0] vec_a, vec_b, exp_bp;
    logic [63:0] bb_vec [2];
    int          waited, nsent, nrecv, hs_cyc;
    logic        acc, ohs;

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        flush     = 1'b0;
        out_ready = 1'b0;
        #3;
        chk1("rst_in_ready", ir[0], 1'b0);
        chk1("rst_out_valid", ov[0], 1'b0);
        chk1("rst_busy", bz[0], 1'b0);
        chk64("rst_out_data", od[0], 64'h0);
        step();
        step();
        #2 rst_n = 1'b1;
        #1 chk1("in_ready_before_edge", ir[0], 1'b0);
        step();
        chk1("in_ready_after_edge", ir[0], 1'b1);

        // Known vector and identity columns across all lane counts, then random ones.
        chk64("model_known", model(64'h8e4da1bc_9fdc589d), 64'hdb135345_f20a225c);
        run_lanes(64'h8e4da1bc_9fdc589d);
        chk64("known_data", od[0], 64'hdb135345_f20a225c);
        run_lanes(64'h01010101_c6c6c6c6);
        chk64("identity_data", od[0], 64'h01010101_c6c6c6c6);
        for (int i = 0; i < 3; i++) run_lanes({$urandom, $urandom});

        // Backpressure: held result, second in_valid ignored.
        vec_a     = {$urandom, $urandom};
        exp_bp    = model(vec_a);
        in_data   = vec_a;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        step();
        in_data = {$urandom, $urandom};
        waited  = 0;
        while (!ov[0] && waited < 20) begin
            step();
            waited++;
        end
        chk1("bp_valid_rise", ov[0], 1'b1);
        for (int i = 0; i < 20; i++) begin
            step();
            chk1("bp_valid_hold", ov[0], 1'b1);
            chk64("bp_data_hold", od[0], exp_bp);
            chk1("bp_in_ready", ir[0], 1'b0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        chk1("bp_release_ready", ir[0], 1'b1);
        chk1("bp_release_valid", ov[0], 1'b0);
        chk1("bp_release_busy", bz[0], 1'b0);

        // Flush during the third RUN cycle.
        vec_b    = {$urandom, $urandom};
        in_data  = vec_b;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk1("flush_busy", bz[0], 1'b0);
        chk1("flush_in_ready", ir[0], 1'b1);
        for (int i = 0; i < 8; i++) begin
            chk1("flush_no_valid", ov[0], 1'b0);
            step();
        end
        send_check("post_flush", 64'h8e4da1bc_9fdc589d);

        // Asynchronous reset in the middle of RUN.
        in_data  = {$urandom, $urandom};
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        step();
        #2 rst_n = 1'b0;
        #1;
        chk1("arst_valid", ov[0], 1'b0);
        chk1("arst_busy", bz[0], 1'b0);
        chk64("arst_data", od[0], 64'h0);
        chk1("arst_in_ready", ir[0], 1'b0);
        #2 rst_n = 1'b1;
        step();
        send_check("post_reset", {$urandom, $urandom});

        // Back-to-back with in_valid held.
        bb_vec[0] = {$urandom, $urandom};
        bb_vec[1] = {$urandom, $urandom};
        in_data   = bb_vec[0];
        in_valid  = 1'b1;
        out_ready = 1'b1;
        nsent     = 0;
        nrecv     = 0;
        hs_cyc    = -10;
        for (int cyc = 0; cyc < 60 && nrecv < 2; cyc++) begin
            acc = in_valid && ir[0];
            ohs = ov[0] && out_ready;
            if (ohs) begin
                chk64($sformatf("b2b_data%0d", nrecv), od[0], model(bb_vec[nrecv]));
                nrecv++;
                hs_cyc = cyc;
            end
            if (acc) begin
                if (nsent == 1) chk64("b2b_accept_cycle", 64'(cyc), 64'(hs_cyc + 1));
                nsent++;
            end
            step();
            if (acc) begin
                if (nsent < 2) in_data = bb_vec[nsent];
                else in_valid = 1'b0;
            end
        end
        chk64("b2b_count", 64'(nrecv), 64'd2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
